// File: rtl/inst_fetch_q_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_q_if
// Brief    : Instruction-memory, decode and redirect bundle for inst_fetch_q.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_q_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [INST_W-1:0] imem_rdata;

   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_pc;
   logic [INST_W-1:0] out_inst;

   logic              branch;
   logic              jmp;
   logic [ADDR_W-1:0] redir_pc;
   logic [15:0]       imm16;
   logic [25:0]       jmp_imm26;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output out_valid, out_pc, out_inst,
      input  out_ready,
      input  branch, jmp, redir_pc, imm16, jmp_imm26
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  out_valid, out_pc, out_inst,
      output out_ready,
      output branch, jmp, redir_pc, imm16, jmp_imm26
   );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_q.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_q
// Brief    : Single-outstanding instruction fetcher feeding a QDEPTH-entry
//            {pc, inst} queue, with branch/jump redirect and flush.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_q #(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter int                QDEPTH   = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic clk,
   input  logic reset,
   inst_fetch_q_if.master bus
);

   localparam int                 c_PTR_W   = $clog2(QDEPTH);
   localparam int                 c_CNT_W   = c_PTR_W + 1;
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(QDEPTH);
   localparam logic [ADDR_W-1:0]  c_FOUR    = ADDR_W'(4);

   typedef enum logic [0:0] {
      S_FETCH   = 1'b0,
      S_DISCARD = 1'b1
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_fetch_pc;
   logic                r_req;
   logic [ADDR_W-1:0]   r_addr;
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [c_CNT_W-1:0]  r_count;
   logic [ADDR_W-1:0]   r_pc_q   [QDEPTH];
   logic [INST_W-1:0]   r_inst_q [QDEPTH];

   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   w_fetch_pc_nxt;
   logic                w_req_nxt;
   logic [ADDR_W-1:0]   w_addr_nxt;
   logic [c_PTR_W-1:0]  w_wr_ptr_nxt;
   logic [c_PTR_W-1:0]  w_rd_ptr_nxt;
   logic [c_CNT_W-1:0]  w_count_nxt;
   logic                w_enq;
   logic                w_deq;
   logic                w_issue;

   logic                w_redirect;
   logic [ADDR_W-1:0]   w_seq_pc;
   logic [ADDR_W-1:0]   w_br_off;
   logic [ADDR_W-1:0]   w_jmp_off;
   logic [ADDR_W-1:0]   w_target;

   // Offsets are byte offsets relative to the instruction after the redirector
   assign w_redirect = bus.branch | bus.jmp;
   assign w_seq_pc   = bus.redir_pc + c_FOUR;
   assign w_br_off   = {{(ADDR_W-16){bus.imm16[15]}}, bus.imm16};
   assign w_jmp_off  = {{(ADDR_W-26){bus.jmp_imm26[25]}}, bus.jmp_imm26};
   assign w_target   = bus.branch ? (w_seq_pc + w_br_off) : (w_seq_pc + w_jmp_off);

   assign w_deq = (r_count != '0) && bus.out_ready && !w_redirect;

   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_req_nxt      = r_req;
      w_addr_nxt     = r_addr;
      w_enq          = 1'b0;
      w_issue        = 1'b0;

      case (r_state)
         S_FETCH: begin
            if (w_redirect) begin
               w_fetch_pc_nxt = w_target;
               if (r_req && !bus.imem_ack) begin
                  w_state_nxt = S_DISCARD;
               end else begin
                  w_issue = 1'b1;
               end
            end else if (!(r_req && !bus.imem_ack)) begin
               if (r_req && (r_count < c_FULL)) begin
                  w_enq          = 1'b1;
                  w_fetch_pc_nxt = r_fetch_pc + c_FOUR;
               end
               w_issue = 1'b1;
            end
         end
         S_DISCARD: begin
            // Request stays parked on its original address until memory answers
            if (w_redirect) begin
               w_fetch_pc_nxt = w_target;
            end
            if (bus.imem_ack) begin
               w_state_nxt = S_FETCH;
               w_issue     = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_FETCH;
         end
      endcase

      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_count_nxt  = r_count;
      if (w_redirect) begin
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
         w_count_nxt  = '0;
      end else begin
         if (w_enq) begin
            w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
         end
         if (w_deq) begin
            w_rd_ptr_nxt = r_rd_ptr + c_PTR_ONE;
         end
         if (w_enq && !w_deq) begin
            w_count_nxt = r_count + c_CNT_ONE;
         end else if (!w_enq && w_deq) begin
            w_count_nxt = r_count - c_CNT_ONE;
         end
      end

      // A new request is only raised when its response is sure to find a slot
      if (w_issue) begin
         w_req_nxt  = (w_count_nxt < c_FULL);
         w_addr_nxt = w_fetch_pc_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_FETCH;
         r_fetch_pc <= RESET_PC;
         r_req      <= 1'b0;
         r_addr     <= RESET_PC;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_req      <= w_req_nxt;
         r_addr     <= w_addr_nxt;
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_rd_ptr   <= w_rd_ptr_nxt;
         r_count    <= w_count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_enq) begin
         r_pc_q[r_wr_ptr]   <= r_fetch_pc;
         r_inst_q[r_wr_ptr] <= bus.imem_rdata;
      end
   end

   assign bus.imem_req  = r_req;
   assign bus.imem_addr = r_addr;
   assign bus.out_valid = (r_count != '0);
   assign bus.out_pc    = r_pc_q[r_rd_ptr];
   assign bus.out_inst  = r_inst_q[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_q.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_q
// Brief    : Self-checking bench for inst_fetch_q (vector tables, directed
//            corner sequences, randomized run against a stream model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_q;

   localparam int ADDR_W = 32;
   localparam int INST_W = 32;
   localparam int QDEPTH = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   inst_fetch_q_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

   inst_fetch_q #(
      .ADDR_W  (ADDR_W),
      .INST_W  (INST_W),
      .QDEPTH  (QDEPTH),
      .RESET_PC(32'h0)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit          rst;
      bit          rdy;
      bit          req;
      logic [31:0] addr;
      bit          vld;
      logic [31:0] pc;
   } seq_vec_t;

   typedef struct {
      bit          br;
      bit          jp;
      logic [31:0] rpc;
      logic [15:0] i16;
      logic [25:0] i26;
      logic [31:0] exp;
   } tgt_vec_t;

   seq_vec_t seq[16];
   tgt_vec_t tv[7];

   bit mem_on    = 1'b0;
   int max_wait  = 0;
   int wait_left = -1;

   bit          mon_en      = 1'b0;
   logic [31:0] model_pc    = 32'h0;
   int          deq_count   = 0;
   bit          prev_pend   = 1'b0;
   logic [31:0] prev_addr   = 32'h0;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   // Architectural target: PC of the next sequential instruction plus signed offset
   function automatic logic [31:0] tgt(input bit br, input logic [31:0] rpc,
                                       input logic [15:0] i16, input logic [25:0] i26);
      int off;
      off = br ? int'($signed(i16)) : int'($signed(i26));
      return rpc + 32'd4 + 32'(off);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_mem();
      if (!mem_on) return;
      bus.imem_rdata = memfn(bus.imem_addr);
      if (bus.imem_req) begin
         if (wait_left < 0) wait_left = $urandom_range(0, max_wait);
         if (wait_left == 0) begin
            bus.imem_ack = 1'b1;
            wait_left = -1;
         end else begin
            bus.imem_ack = 1'b0;
            wait_left--;
         end
      end else begin
         bus.imem_ack = 1'b0;
         wait_left = -1;
      end
   endtask

   task automatic clear_redirect();
      bus.branch    = 1'b0;
      bus.jmp       = 1'b0;
      bus.redir_pc  = 32'h0;
      bus.imm16     = 16'h0;
      bus.jmp_imm26 = 26'h0;
   endtask

   // Reset, then land in the first cycle with a request outstanding (addr RESET_PC)
   task automatic reset_to_first_req();
      mem_on        = 1'b0;
      bus.imem_ack  = 1'b0;
      bus.out_ready = 1'b0;
      clear_redirect();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   // Monitor: the dequeued stream must follow sequential PCs from the last target
   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_pend) begin
            check("hold_req", 32'(bus.imem_req), 32'h1);
            check("hold_addr", bus.imem_addr, prev_addr);
         end
         prev_pend = bus.imem_req && !bus.imem_ack;
         prev_addr = bus.imem_addr;
         if (bus.branch || bus.jmp) begin
            model_pc = tgt(bus.branch, bus.redir_pc, bus.imm16, bus.jmp_imm26);
         end else if (bus.out_valid && bus.out_ready) begin
            check("rand_pc", bus.out_pc, model_pc);
            check("rand_inst", bus.out_inst, memfn(model_pc));
            model_pc = model_pc + 32'd4;
            deq_count++;
         end
      end
   end

   initial begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h0;
      bus.out_ready  = 1'b0;
      clear_redirect();

      //           rst   rdy   req   addr      vld   pc
      seq[0]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
      seq[1]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
      seq[2]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00};
      seq[3]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
      seq[4]  = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h08};
      seq[5]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
      seq[6]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
      seq[7]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
      seq[8]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
      seq[9]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
      seq[10] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
      seq[11] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
      seq[12] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
      seq[13] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
      seq[14] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
      seq[15] = '{1'b0, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};

      //          br    jp    redir_pc       imm16     jmp_imm26     expected
      tv[0] = '{1'b1, 1'b0, 32'h0000_0100, 16'hFFF0, 26'h0,       32'h0000_00F4};
      tv[1] = '{1'b1, 1'b1, 32'h0000_0040, 16'h0008, 26'h400,     32'h0000_004C};
      tv[2] = '{1'b0, 1'b1, 32'h0000_0040, 16'h0008, 26'h400,     32'h0000_0444};
      tv[3] = '{1'b0, 1'b1, 32'h0000_1000, 16'h0000, 26'h3FFFFFC, 32'h0000_1000};
      tv[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 16'h0010, 26'h0,       32'h0000_0010};
      tv[5] = '{1'b1, 1'b0, 32'h0001_0000, 16'h8000, 26'h0,       32'h0000_8004};
      tv[6] = '{1'b0, 1'b1, 32'h0300_0000, 16'h0000, 26'h2000000, 32'h0100_0004};

      // Zero-wait streaming, reset, fill-to-full, then drain and resume
      mem_on   = 1'b1;
      max_wait = 0;
      reset    = 1'b1;
      step();
      step();
      for (int i = 0; i < 16; i++) begin
         check($sformatf("seq%0d_req", i), 32'(bus.imem_req), 32'(seq[i].req));
         if (seq[i].req) check($sformatf("seq%0d_addr", i), bus.imem_addr, seq[i].addr);
         check($sformatf("seq%0d_valid", i), 32'(bus.out_valid), 32'(seq[i].vld));
         if (seq[i].vld) begin
            check($sformatf("seq%0d_pc", i), bus.out_pc, seq[i].pc);
            check($sformatf("seq%0d_inst", i), bus.out_inst, memfn(seq[i].pc));
         end
         reset         = seq[i].rst;
         bus.out_ready = seq[i].rdy;
         drive_mem();
         step();
      end

      // Redirect coinciding with an ack: response dropped, target fetched next
      for (int i = 0; i < 7; i++) begin
         reset_to_first_req();
         check($sformatf("tgt%0d_pre_req", i), 32'(bus.imem_req), 32'h1);
         bus.branch     = tv[i].br;
         bus.jmp        = tv[i].jp;
         bus.redir_pc   = tv[i].rpc;
         bus.imm16      = tv[i].i16;
         bus.jmp_imm26  = tv[i].i26;
         bus.imem_ack   = 1'b1;
         bus.imem_rdata = 32'hDEAD_BEEF;
         step();
         check($sformatf("tgt%0d_req", i), 32'(bus.imem_req), 32'h1);
         check($sformatf("tgt%0d_addr", i), bus.imem_addr, tv[i].exp);
         check($sformatf("tgt%0d_valid", i), 32'(bus.out_valid), 32'h0);
         clear_redirect();
         bus.imem_ack = 1'b0;
      end

      // Reset with two entries queued and a request pending
      reset_to_first_req();
      bus.imem_ack = 1'b1; bus.imem_rdata = memfn(32'h0);
      step();
      bus.imem_ack = 1'b1; bus.imem_rdata = memfn(32'h4);
      step();
      bus.imem_ack = 1'b0;
      step();
      check("rst_pend_req", 32'(bus.imem_req), 32'h1);
      check("rst_pend_addr", bus.imem_addr, 32'h8);
      check("rst_pend_pc", bus.out_pc, 32'h0);
      reset = 1'b1;
      step();
      check("rst_next_valid", 32'(bus.out_valid), 32'h0);
      check("rst_next_req", 32'(bus.imem_req), 32'h0);
      reset = 1'b0;
      step();
      check("rst_after_req", 32'(bus.imem_req), 32'h1);
      check("rst_after_addr", bus.imem_addr, 32'h0);

      // Redirect in the first wait cycle of a three-cycle response
      reset_to_first_req();
      bus.jmp = 1'b1; bus.redir_pc = 32'h1FC; bus.jmp_imm26 = 26'h0;
      step();
      clear_redirect();
      check("disc_w2_req", 32'(bus.imem_req), 32'h1);
      check("disc_w2_addr", bus.imem_addr, 32'h0);
      step();
      check("disc_w3_addr", bus.imem_addr, 32'h0);
      bus.imem_ack = 1'b1; bus.imem_rdata = memfn(32'h0);
      step();
      check("disc_post_addr", bus.imem_addr, 32'h200);
      check("disc_post_valid", 32'(bus.out_valid), 32'h0);
      bus.imem_ack = 1'b1; bus.imem_rdata = memfn(32'h200);
      step();
      bus.imem_ack = 1'b0;
      check("disc_tgt_valid", 32'(bus.out_valid), 32'h1);
      check("disc_tgt_pc", bus.out_pc, 32'h200);
      check("disc_tgt_inst", bus.out_inst, memfn(32'h200));

      // Randomized run: variable latency, back-pressure and redirects
      reset_to_first_req();
      model_pc  = 32'h0;
      deq_count = 0;
      prev_pend = 1'b0;
      mem_on    = 1'b1;
      max_wait  = 3;
      wait_left = -1;
      mon_en    = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         bus.out_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0) begin
            bus.branch    = $urandom_range(0, 1) == 1;
            bus.jmp       = bus.branch ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.redir_pc  = $urandom;
            bus.imm16     = 16'($urandom);
            bus.jmp_imm26 = 26'($urandom);
         end else begin
            clear_redirect();
         end
         drive_mem();
         step();
      end
      mon_en = 1'b0;
      checks++;
      if (deq_count < 300) begin
         failures++;
         $display("FAIL rand_progress actual=%0d required>=300", deq_count);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
